// File: rtl/if_pc_unit_pkg.sv
// Shared IF-stage definitions: FSM state encoding, HALT opcode and default PC width.
// Also used by the debug unit and the IF/ID latch.
package if_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } pc_state_e;

    localparam int unsigned IF_NB_PC       = 32;
    localparam logic [5:0]  IF_HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/if_pc_next_mux.sv
// Next-PC priority select: jump over branch over the sequential PC+1 from the IF adder.
module if_pc_next_mux #(
    parameter int NB_PC = 32
) (
    input  logic             jump_i,
    input  logic [NB_PC-1:0] jump_target_i,
    input  logic             branch_taken_i,
    input  logic [NB_PC-1:0] branch_target_i,
    input  logic [NB_PC-1:0] pc_4_i,
    output logic [NB_PC-1:0] next_pc_o,
    output logic             redirect_o
);

    always_comb begin
        next_pc_o = pc_4_i;
        if (jump_i) begin
            next_pc_o = jump_target_i;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i;
        end
    end

    assign redirect_o = jump_i | branch_taken_i;

endmodule

// File: rtl/if_pc_unit.sv
// IF-stage program counter with run/step/halt control and a saturating cycle counter.
// Optional instruction-memory bounds check enabled by defining IF_PC_BOUNDS_CHECK_EN.
module if_pc_unit
    import if_pc_unit_pkg::*;
#(
    parameter int         NB_PC       = IF_NB_PC,
    parameter int         NB_CYCLES   = 32,
    parameter int         IMEM_DEPTH  = 256,
    parameter logic [5:0] HALT_OPCODE = IF_HALT_OPCODE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [NB_PC-1:0]     i_branch_target,
    input  logic                 i_jump,
    input  logic [NB_PC-1:0]     i_jump_target,
    input  logic [NB_PC-1:0]     i_pc_4,
    input  logic [31:0]          i_instr,
    output logic [NB_PC-1:0]     o_pc,
    output logic                 o_valid,
    output logic                 o_halted,
    output logic [NB_CYCLES-1:0] o_cycles,
`ifdef IF_PC_BOUNDS_CHECK_EN
    output logic                 o_pc_fault,
`endif
    output logic [1:0]           o_state
);

    pc_state_e              state_q, state_d;
    logic [NB_PC-1:0]       pc_q, pc_d;
    logic [NB_CYCLES-1:0]   cyc_q, cyc_d;
    logic                   step_q;
    logic                   adv, active, step_edge, halt_op, load;
    logic [NB_PC-1:0]       next_pc;
    logic                   redirect;
`ifdef IF_PC_BOUNDS_CHECK_EN
    localparam logic [NB_PC:0] DEPTH_L = (NB_PC+1)'(IMEM_DEPTH);
    logic                   fault_q, fault_d;
    logic                   unused_instr;
    assign unused_instr = ^i_instr[25:0];
`else
    logic                   unused_cfg;
    assign unused_cfg = ^{i_instr[25:0], 32'(IMEM_DEPTH)};
`endif

    if_pc_next_mux #(.NB_PC(NB_PC)) u_next_mux (
        .jump_i          (i_jump),
        .jump_target_i   (i_jump_target),
        .branch_taken_i  (i_branch_taken),
        .branch_target_i (i_branch_target),
        .pc_4_i          (i_pc_4),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect)
    );

    always_comb begin
        active    = (state_q == ST_RUN) || (state_q == ST_STEP);
        step_edge = i_step && !step_q;
        halt_op   = (i_instr[31:26] == HALT_OPCODE);
        case (state_q)
            ST_RUN:  adv = !i_stall;
            ST_STEP: adv = step_edge && !i_stall;
            default: adv = 1'b0;
        endcase
        // A redirect flushes even through a stall; a HALT fetch only freezes the PC without one.
        load    = active && (redirect ? (adv || i_stall) : (adv && !halt_op));
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
`ifdef IF_PC_BOUNDS_CHECK_EN
        fault_d = fault_q;
`endif
        if ((state_q == ST_IDLE) && i_start) begin
            state_d = i_step_mode ? ST_STEP : ST_RUN;
        end
        if (adv && halt_op && !redirect) begin
            state_d = ST_HALT;
        end
        if (load) begin
`ifdef IF_PC_BOUNDS_CHECK_EN
            if ({1'b0, next_pc} >= DEPTH_L) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
`else
            pc_d = next_pc;
`endif
        end
        if (adv && (cyc_q != '1)) begin
            cyc_d = cyc_q + NB_CYCLES'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            step_q  <= 1'b0;
`ifdef IF_PC_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            step_q  <= i_step;
`ifdef IF_PC_BOUNDS_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign o_pc     = pc_q;
    assign o_valid  = adv;
    assign o_halted = (state_q == ST_HALT);
    assign o_cycles = cyc_q;
    assign o_state  = state_q;
`ifdef IF_PC_BOUNDS_CHECK_EN
    assign o_pc_fault = fault_q;
`endif

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit with a cycle-level reference model and literal spot checks.
module tb_if_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step_mode, step, stall, branch, jump;
    logic [31:0] bt, jt, instr;
    logic [31:0] pc_4;
    logic [31:0] o_pc;
    logic        o_valid, o_halted;
    logic [31:0] o_cycles;
    logic [1:0]  o_state;
`ifdef IF_PC_BOUNDS_CHECK_EN
    logic        o_pc_fault;
    localparam logic [31:0] DEPTH = 32'd256;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pc_4 = o_pc + 32'd1;

    if_pc_unit #(.NB_PC(32), .NB_CYCLES(32), .IMEM_DEPTH(256)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_branch_taken  (branch),
        .i_branch_target (bt),
        .i_jump          (jump),
        .i_jump_target   (jt),
        .i_pc_4          (pc_4),
        .i_instr         (instr),
        .o_pc            (o_pc),
        .o_valid         (o_valid),
        .o_halted        (o_halted),
        .o_cycles        (o_cycles),
`ifdef IF_PC_BOUNDS_CHECK_EN
        .o_pc_fault      (o_pc_fault),
`endif
        .o_state         (o_state)
    );

    // Reference model: state as plain integers (0 idle, 1 run, 2 step, 3 halt)
    int          m_st;
    logic [31:0] m_pc, m_cyc;
    bit          m_stq, m_fault;

    function automatic bit exp_adv();
        if (m_st == 1) return !stall;
        if (m_st == 2) return step && !m_stq && !stall;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_pc = 0; m_cyc = 0; m_stq = 0; m_fault = 0;
        end else begin
            bit          go;
            bit          redir;
            bit          take;
            logic [31:0] tgt;
            go    = exp_adv();
            redir = jump || branch;
            tgt   = jump ? jt : (branch ? bt : m_pc + 32'd1);
            take  = (redir && (go || stall)) || (go && instr[31:26] != 6'h3F);
            if (m_st == 0) begin
                if (start) m_st = step_mode ? 2 : 1;
            end else if (m_st != 3) begin
                if (take) begin
`ifdef IF_PC_BOUNDS_CHECK_EN
                    if (tgt >= DEPTH) begin
                        m_st = 3; m_fault = 1;
                    end else begin
                        m_pc = tgt;
                    end
`else
                    m_pc = tgt;
`endif
                end else if (go) begin
                    m_st = 3;
                end
            end
            if (go && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
            m_stq = step;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_pc",     64'(o_pc),     64'(m_pc));
            chk("model_state",  64'(o_state),  64'(m_st));
            chk("model_halted", 64'(o_halted), 64'(m_st == 3));
            chk("model_cycles", 64'(o_cycles), 64'(m_cyc));
            chk("model_valid",  64'(o_valid),  64'(exp_adv()));
`ifdef IF_PC_BOUNDS_CHECK_EN
            chk("model_fault",  64'(o_pc_fault), 64'(m_fault));
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; step = 0; stall = 0;
        branch = 0; jump = 0; bt = 0; jt = 0; instr = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        tick(2);
        chk("rst_pc",     64'(o_pc),     64'd0);
        chk("rst_valid",  64'(o_valid),  64'd0);
        chk("rst_state",  64'(o_state),  64'd0);
        chk("rst_cycles", 64'(o_cycles), 64'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_pc_hold", 64'(o_pc), 64'd0);

        // Continuous run
        start = 1; tick(); start = 0;
        tick(3);
        chk("run_pc3",    64'(o_pc),     64'd3);
        chk("run_cyc3",   64'(o_cycles), 64'd3);
        chk("run_state",  64'(o_state),  64'd1);

        // Stall at PC 5, then branch redirect under stall
        tick(2);
        chk("pc5", 64'(o_pc), 64'd5);
        stall = 1; #1;
        chk("stall_valid", 64'(o_valid), 64'd0);
        tick(2);
        chk("stall_pc_hold", 64'(o_pc), 64'd5);
        stall = 0; tick();
        chk("resume_pc6", 64'(o_pc), 64'd6);
        stall = 1; branch = 1; bt = 32'h20; tick();
        chk("branch_under_stall", 64'(o_pc), 64'h20);
        chk("stall_cyc", 64'(o_cycles), 64'd6);
        stall = 0; branch = 0;

        // Jump beats branch
        jump = 1; jt = 32'h40; branch = 1; bt = 32'h10; tick();
        chk("jump_priority", 64'(o_pc), 64'h40);
        jump = 0; branch = 0;
        tick();

        // Asynchronous reset between edges
        rst_n = 1'b0; #1;
        chk("async_pc",     64'(o_pc),     64'd0);
        chk("async_state",  64'(o_state),  64'd0);
        chk("async_cycles", 64'(o_cycles), 64'd0);
        chk("async_valid",  64'(o_valid),  64'd0);
        tick(); rst_n = 1'b1; tick();

        // Single-step mode
        step_mode = 1; start = 1; tick(); start = 0; step_mode = 0;
        chk("step_state", 64'(o_state), 64'd2);
        step = 1; tick(5);
        chk("step_held", 64'(o_pc), 64'd1);
        step = 0; tick();
        step = 1; tick();
        step = 0; tick();
        chk("step_pc2",  64'(o_pc),     64'd2);
        chk("step_cyc2", 64'(o_cycles), 64'd2);
        stall = 1; step = 1; tick();
        stall = 0; step = 0; tick();
        chk("step_lost_in_stall", 64'(o_pc), 64'd2);

        // HALT detection
        do_reset();
        start = 1; tick(); start = 0;
        tick(7);
        chk("halt_setup_pc7", 64'(o_pc), 64'd7);
        instr = 32'hFC00_0000; jump = 1; jt = 32'd7; tick();
        chk("halt_ignored_state", 64'(o_state), 64'd1);
        jump = 0; #1;
        chk("halt_valid", 64'(o_valid), 64'd1);
        tick();
        chk("halt_state",  64'(o_state),  64'd3);
        chk("halt_flag",   64'(o_halted), 64'd1);
        chk("halt_pc",     64'(o_pc),     64'd7);
        chk("halt_cycles", 64'(o_cycles), 64'd9);
        instr = 32'h0; start = 1; tick(3); start = 0;
        chk("halt_sticky_state", 64'(o_state), 64'd3);
        chk("halt_sticky_pc",    64'(o_pc),    64'd7);

`ifdef IF_PC_BOUNDS_CHECK_EN
        do_reset();
        start = 1; tick(); start = 0;
        jump = 1; jt = 32'hFF; tick(); jump = 0;
        chk("bounds_pc_last", 64'(o_pc), 64'hFF);
        tick();
        chk("bounds_fault",  64'(o_pc_fault), 64'd1);
        chk("bounds_halted", 64'(o_halted),   64'd1);
        chk("bounds_pc",     64'(o_pc),       64'hFF);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
